// File: rtl/w_writeback_grf_if.sv
// W-stage bundle and D-stage register-file read ports of the writeback/GRF block.
// The slave side is the register file. The master side is the pipeline that feeds it.
interface w_writeback_grf_if;
   logic [31:0] W_Instr;
   logic [31:0] W_PC8;
   logic [31:0] W_RD;
   logic [31:0] W_Result;
   logic [4:0]  D_RA1;
   logic [4:0]  D_RA2;
   logic [31:0] D_RD1;
   logic [31:0] D_RD2;
   logic        W_WE;
   logic [4:0]  W_WA;
   logic [31:0] W_WD;

   modport master (
      output W_Instr, W_PC8, W_RD, W_Result, D_RA1, D_RA2,
      input  D_RD1, D_RD2, W_WE, W_WA, W_WD
   );

   modport slave (
      input  W_Instr, W_PC8, W_RD, W_Result, D_RA1, D_RA2,
      output D_RD1, D_RD2, W_WE, W_WA, W_WD
   );
endinterface

// File: rtl/w_writeback_grf.sv
// W-stage writeback: decodes destination and data, extracts sub-word loads, and commits
// to the 32x32 GRF. The two D-stage read ports bypass the value being written this cycle.
module w_writeback_grf (
   input  logic                  clk,
   input  logic                  reset,
   w_writeback_grf_if.slave      bus
);

   typedef enum logic [1:0] {WD_NONE, WD_RESULT, WD_PC8, WD_LOAD} wd_src_e;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_LHU     = 6'b100101;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rt;
   logic [4:0]  rd;
   wd_src_e     wd_src;
   logic [4:0]  wa_dec;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] wd_dec;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [31:0] regs [32];

   assign op = bus.W_Instr[31:26];
   assign fn = bus.W_Instr[5:0];
   assign rt = bus.W_Instr[20:16];
   assign rd = bus.W_Instr[15:11];

   // NOTE: every always_comb assigns its outputs a default first, so no path leaves a latch.
   always_comb begin
      wd_src = WD_NONE;
      wa_dec = '0;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
               FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_MFHI, FN_MFLO: begin
                  wd_src = WD_RESULT;
                  wa_dec = rd;
               end
               FN_JALR: begin
                  wd_src = WD_PC8;
                  wa_dec = rd;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            wd_src = WD_RESULT;
            wa_dec = rt;
         end
         OP_JAL: begin
            wd_src = WD_PC8;
            wa_dec = 5'd31;
         end
         OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
            wd_src = WD_LOAD;
            wa_dec = rt;
         end
         default: ;
      endcase
   end

   // Little-endian lane select. The low address bit is ignored for halfwords.
   assign ld_byte = bus.W_RD[{bus.W_Result[1:0], 3'b000} +: 8];
   assign ld_half = bus.W_RD[{bus.W_Result[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = bus.W_RD;
      case (op)
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_data = {24'd0, ld_byte};
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_data = {16'd0, ld_half};
         default: ld_data = bus.W_RD;
      endcase
   end

   always_comb begin
      wd_dec = '0;
      case (wd_src)
         WD_RESULT: wd_dec = bus.W_Result;
         WD_PC8:    wd_dec = bus.W_PC8;
         WD_LOAD:   wd_dec = ld_data;
         default:   wd_dec = '0;
      endcase
   end

   // Writes to $0 are dropped here, so the hazard unit never sees a phantom producer.
   assign we = (wd_src != WD_NONE) && (wa_dec != 5'd0);
   assign wa = we ? wa_dec : 5'd0;
   assign wd = we ? wd_dec : 32'd0;

   assign bus.W_WE = we;
   assign bus.W_WA = wa;
   assign bus.W_WD = wd;

   // NOTE: the array is cleared on reset because software may read registers before
   // writing them. Sequential state uses <= only.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] ra);
      if (ra == 5'd0)           return 32'd0;
      else if (we && (wa == ra)) return wd;
      else                       return regs[ra];
   endfunction

   always_comb bus.D_RD1 = read_port(bus.D_RA1);
   always_comb bus.D_RD2 = read_port(bus.D_RA2);

endmodule

// File: tb/tb_w_writeback_grf.sv
// Scoreboard bench for w_writeback_grf: the driver pushes model expectations and
// the monitor compares them against the DUT mid-cycle, before the committing edge.
module tb_w_writeback_grf;

   logic clk;
   logic reset;
   w_writeback_grf_if bus();

   w_writeback_grf dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      bit          chk_rd;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_regs [32];
   int          tests;
   int          failed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference decode, taken directly from the instruction-class table.
   function automatic void model_decode(input logic [31:0] ins, input logic [31:0] pc8,
                                        input logic [31:0] rdw, input logic [31:0] res,
                                        output logic we, output logic [4:0] wa,
                                        output logic [31:0] wd);
      int op, fn, rt, rd, dst, k, v;
      bit wr;
      logic [31:0] val;
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      wr = 1'b0; dst = 0; val = 32'd0;
      if (op == 0 && fn inside {32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 16, 18}) begin
         wr = 1; dst = rd; val = res;
      end else if (op == 0 && fn == 9) begin
         wr = 1; dst = rd; val = pc8;
      end else if (op inside {[8:15]}) begin
         wr = 1; dst = rt; val = res;
      end else if (op == 3) begin
         wr = 1; dst = 31; val = pc8;
      end else if (op == 35) begin
         wr = 1; dst = rt; val = rdw;
      end else if (op == 32 || op == 36) begin
         k = int'(res % 4);
         v = int'((rdw >> (8 * k)) & 32'hFF);
         if (op == 32 && v >= 128) v = v - 256;
         wr = 1; dst = rt; val = v;
      end else if (op == 33 || op == 37) begin
         k = int'((res / 2) % 2);
         v = int'((rdw >> (16 * k)) & 32'hFFFF);
         if (op == 33 && v >= 32768) v = v - 65536;
         wr = 1; dst = rt; val = v;
      end
      we = wr && (dst != 0);
      wa = we ? 5'(dst) : 5'd0;
      wd = we ? val : 32'd0;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (ra == 0) return 32'd0;
      if (we && wa == ra) return wd;
      return model_regs[ra];
   endfunction

   task automatic apply(input string name, input logic rst, input logic [31:0] ins,
                        input logic [31:0] pc8, input logic [31:0] rdw, input logic [31:0] res,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input bit has_known = 0, input logic [31:0] known = 32'd0);
      exp_t e;
      logic we;
      logic [4:0] wa;
      logic [31:0] wd;
      @(negedge clk);
      reset = rst;
      bus.W_Instr = ins; bus.W_PC8 = pc8; bus.W_RD = rdw; bus.W_Result = res;
      bus.D_RA1 = ra1; bus.D_RA2 = ra2;
      model_decode(ins, pc8, rdw, res, we, wa, wd);
      e.name = name; e.we = we; e.wa = wa;
      e.wd = has_known ? known : wd;
      e.rd1 = model_read(ra1, we, wa, wd);
      e.rd2 = model_read(ra2, we, wa, wd);
      e.chk_rd = !rst;
      exp_q.push_back(e);
      if (rst) begin
         for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      end else if (we) begin
         model_regs[wa] = wd;
      end
   endtask

   task automatic readback_all(input string name);
      for (int i = 0; i < 32; i++)
         apply(name, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Monitor: samples combinational outputs mid-cycle, ahead of the committing edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".we"}, 32'(bus.W_WE), 32'(e.we));
            check({e.name, ".wa"}, 32'(bus.W_WA), 32'(e.wa));
            check({e.name, ".wd"}, bus.W_WD, e.wd);
            if (e.chk_rd) begin
               check({e.name, ".rd1"}, bus.D_RD1, e.rd1);
               check({e.name, ".rd2"}, bus.D_RD2, e.rd2);
            end
         end
      end
   end

   localparam logic [31:0] LD_WORD = 32'h80F17F02;

   initial begin
      logic [5:0]  r_fns [18];
      logic [5:0]  i_ops [8];
      logic [5:0]  ld_ops [5];
      logic [31:0] ins;
      logic [4:0]  a, b, c, ra1, ra2;
      int          sel, waited;

      r_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12};
      i_ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      ld_ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
      tests = 0; failed = 0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      reset = 1'b1;
      bus.W_Instr = '0; bus.W_PC8 = '0; bus.W_RD = '0; bus.W_Result = '0;
      bus.D_RA1 = '0; bus.D_RA2 = '0;

      apply("reset0", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      apply("reset1", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
      readback_all("rb_reset");

      apply("ori5", 1'b0, 32'h34050ABC, 32'd0, 32'd0, 32'h00000ABC, 5'd5, 5'd0, 1, 32'h00000ABC);
      apply("ori5_after", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5);

      apply("lb_01",  1'b0, i_ins(6'h20, 5'd1, 5'd8,  16'd1), 32'd0, LD_WORD, 32'h1001, 5'd8,  5'd0, 1, 32'h0000007F);
      apply("lb_10",  1'b0, i_ins(6'h20, 5'd1, 5'd9,  16'd2), 32'd0, LD_WORD, 32'h1002, 5'd9,  5'd8, 1, 32'hFFFFFFF1);
      apply("lbu_11", 1'b0, i_ins(6'h24, 5'd1, 5'd10, 16'd3), 32'd0, LD_WORD, 32'h1003, 5'd10, 5'd9, 1, 32'h00000080);
      apply("lh_1",   1'b0, i_ins(6'h21, 5'd1, 5'd11, 16'd2), 32'd0, LD_WORD, 32'h1003, 5'd11, 5'd11, 1, 32'hFFFF80F1);
      apply("lhu_0",  1'b0, i_ins(6'h25, 5'd1, 5'd12, 16'd0), 32'd0, LD_WORD, 32'h1001, 5'd12, 5'd10, 1, 32'h00007F02);

      apply("jal", 1'b0, 32'h0C000C04, 32'h00003010, 32'd0, 32'hDEAD0000, 5'd31, 5'd0, 1, 32'h00003010);
      apply("jalr_rd0", 1'b0, r_ins(5'd3, 5'd0, 5'd0, 6'h09), 32'h00004000, 32'd0, 32'd7, 5'd0, 5'd31, 1, 32'd0);

      apply("sw",   1'b0, i_ins(6'h2B, 5'd1, 5'd5, 16'd4), 32'h111, 32'h222, 32'h333, 5'd5, 5'd1);
      apply("beq",  1'b0, i_ins(6'h04, 5'd5, 5'd6, 16'd4), 32'h111, 32'h222, 32'h333, 5'd6, 5'd5);
      apply("jr",   1'b0, r_ins(5'd31, 5'd0, 5'd0, 6'h08), 32'h111, 32'h222, 32'h333, 5'd31, 5'd2);
      apply("mult", 1'b0, r_ins(5'd4, 5'd5, 5'd6, 6'h18), 32'h111, 32'h222, 32'h333, 5'd6, 5'd4);
      apply("mthi", 1'b0, r_ins(5'd4, 5'd0, 5'd7, 6'h11), 32'h111, 32'h222, 32'h333, 5'd7, 5'd4);
      apply("op3f", 1'b0, 32'hFC0A5555, 32'h111, 32'h222, 32'h333, 5'd10, 5'd12);
      readback_all("rb_nonwr");

      apply("addu7_rst", 1'b1, r_ins(5'd1, 5'd2, 5'd7, 6'h21), 32'd0, 32'd0, 32'h12345678, 5'd7, 5'd0, 1, 32'h12345678);
      apply("rd7_cleared", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd5, 1, 32'd0);
      apply("addu7", 1'b0, r_ins(5'd1, 5'd2, 5'd7, 6'h21), 32'd0, 32'd0, 32'h12345678, 5'd7, 5'd7, 1, 32'h12345678);
      apply("rd7_kept", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd7);

      for (int n = 0; n < 400; n++) begin
         a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
         sel = $urandom_range(0, 7);
         case (sel)
            0, 1: ins = r_ins(a, b, c, r_fns[$urandom_range(0, 17)]);
            2: ins = i_ins(i_ops[$urandom_range(0, 7)], a, b, 16'($urandom));
            3: ins = i_ins(ld_ops[$urandom_range(0, 4)], a, b, 16'($urandom));
            4: ins = ($urandom_range(0, 1) == 0) ? {6'h03, 26'($urandom)} : r_ins(a, 5'd0, c, 6'h09);
            5: ins = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            default: ins = i_ins(6'h0D, a, b, 16'($urandom));
         endcase
         ra1 = ($urandom_range(0, 2) == 0) ? ins[20:16] : 5'($urandom);
         ra2 = ($urandom_range(0, 2) == 0) ? ins[15:11] : 5'($urandom);
         if ($urandom_range(0, 5) == 0) ra2 = ra1;
         apply("rand", ($urandom_range(0, 63) == 0), ins, $urandom, $urandom, $urandom, ra1, ra2);
      end
      readback_all("rb_final");

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      #4;
      if (exp_q.size() > 0) begin
         failed++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
